// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use hazard detection, flush and hold handling.
// Optional bubble counter enabled by defining IDEX_BUBBLE_CNT_EN.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic          id_beq,
  input  logic          id_bne,
  input  logic          id_mem_to_reg,
  input  logic          id_mem_write,
  input  logic          id_alu_src_b,
  input  logic          id_reg_write,
  input  logic          id_reg_dst,
  input  logic          id_jal,
  input  logic          id_jmp,
  input  logic          id_jr,
  input  logic          id_syscall,
  input  logic [3:0]    id_alu_op,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [DW-1:0] id_pc,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [RW-1:0] id_shamt,
  input  logic          flush,
  input  logic          hold,
  output logic          ex_valid,
  output logic          ex_beq,
  output logic          ex_bne,
  output logic          ex_mem_to_reg,
  output logic          ex_mem_write,
  output logic          ex_alu_src_b,
  output logic          ex_reg_write,
  output logic          ex_reg_dst,
  output logic          ex_jal,
  output logic          ex_jmp,
  output logic          ex_jr,
  output logic          ex_syscall,
  output logic [3:0]    ex_alu_op,
  output logic          ex_use_rs,
  output logic          ex_use_rt,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_shamt,
  output logic [RW-1:0] ex_dst,
  output logic          load_use_stall,
  output logic [31:0]   bubble_cnt
);

  typedef struct packed {
    logic          valid;
    logic          beq;
    logic          bne;
    logic          mem_to_reg;
    logic          mem_write;
    logic          alu_src_b;
    logic          reg_write;
    logic          reg_dst;
    logic          jal;
    logic          jmp;
    logic          jr;
    logic          syscall;
    logic [3:0]    alu_op;
    logic          use_rs;
    logic          use_rt;
    logic [DW-1:0] pc;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] shamt;
    logic [RW-1:0] dst;
  } idex_t;

  idex_t ex_q, ex_d, id_cap;

  // An invalid ID slot is captured as an all-zero bubble.
  always_comb begin
    id_cap = '0;
    if (id_valid) begin
      id_cap.valid      = 1'b1;
      id_cap.beq        = id_beq;
      id_cap.bne        = id_bne;
      id_cap.mem_to_reg = id_mem_to_reg;
      id_cap.mem_write  = id_mem_write;
      id_cap.alu_src_b  = id_alu_src_b;
      id_cap.reg_write  = id_reg_write;
      id_cap.reg_dst    = id_reg_dst;
      id_cap.jal        = id_jal;
      id_cap.jmp        = id_jmp;
      id_cap.jr         = id_jr;
      id_cap.syscall    = id_syscall;
      id_cap.alu_op     = id_alu_op;
      id_cap.use_rs     = id_use_rs;
      id_cap.use_rt     = id_use_rt;
      id_cap.pc         = id_pc;
      id_cap.rs_data    = id_rs_data;
      id_cap.rt_data    = id_rt_data;
      id_cap.imm        = id_imm;
      id_cap.rs         = id_rs;
      id_cap.rt         = id_rt;
      id_cap.shamt      = id_shamt;
      id_cap.dst        = id_jal ? RW'(31) : (id_reg_dst ? id_rd : id_rt);
    end
  end

  // A load into $0 never stalls since ex_dst=0 is excluded.
  assign load_use_stall = id_valid & ex_q.valid & ex_q.mem_to_reg & (ex_q.dst != '0)
                        & ((id_use_rs & (id_rs == ex_q.dst)) | (id_use_rt & (id_rt == ex_q.dst)))
                        & ~flush;

  always_comb begin
    ex_d = ex_q;
    if (flush)               ex_d = '0;
    else if (hold)           ex_d = ex_q;
    else if (load_use_stall) ex_d = '0;
    else                     ex_d = id_cap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        bubble_ins;

  // Only hazard-generated bubbles count; hold and empty ID slots do not.
  assign bubble_ins = flush | (~hold & load_use_stall);
  assign cnt_d      = bubble_ins ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign bubble_cnt = cnt_q;
`else
  assign bubble_cnt = 32'd0;
`endif

  assign ex_valid      = ex_q.valid;
  assign ex_beq        = ex_q.beq;
  assign ex_bne        = ex_q.bne;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_alu_src_b  = ex_q.alu_src_b;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_jal        = ex_q.jal;
  assign ex_jmp        = ex_q.jmp;
  assign ex_jr         = ex_q.jr;
  assign ex_syscall    = ex_q.syscall;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_use_rs     = ex_q.use_rs;
  assign ex_use_rt     = ex_q.use_rt;
  assign ex_pc         = ex_q.pc;
  assign ex_rs_data    = ex_q.rs_data;
  assign ex_rt_data    = ex_q.rt_data;
  assign ex_imm        = ex_q.imm;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_shamt      = ex_q.shamt;
  assign ex_dst        = ex_q.dst;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard scenarios followed by randomized traffic.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          id_valid, id_beq, id_bne, id_mem_to_reg, id_mem_write, id_alu_src_b;
  logic          id_reg_write, id_reg_dst, id_jal, id_jmp, id_jr, id_syscall;
  logic [3:0]    id_alu_op;
  logic          id_use_rs, id_use_rt;
  logic [DW-1:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [RW-1:0] id_rs, id_rt, id_rd, id_shamt;
  logic          flush, hold;
  logic          ex_valid, ex_beq, ex_bne, ex_mem_to_reg, ex_mem_write, ex_alu_src_b;
  logic          ex_reg_write, ex_reg_dst, ex_jal, ex_jmp, ex_jr, ex_syscall;
  logic [3:0]    ex_alu_op;
  logic          ex_use_rs, ex_use_rt;
  logic [DW-1:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [RW-1:0] ex_rs, ex_rt, ex_shamt, ex_dst;
  logic          load_use_stall;
  logic [31:0]   bubble_cnt;

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_beq(id_beq), .id_bne(id_bne), .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
    .id_alu_src_b(id_alu_src_b), .id_reg_write(id_reg_write), .id_reg_dst(id_reg_dst),
    .id_jal(id_jal), .id_jmp(id_jmp), .id_jr(id_jr), .id_syscall(id_syscall),
    .id_alu_op(id_alu_op), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_write(ex_mem_write), .ex_alu_src_b(ex_alu_src_b), .ex_reg_write(ex_reg_write),
    .ex_reg_dst(ex_reg_dst), .ex_jal(ex_jal), .ex_jmp(ex_jmp), .ex_jr(ex_jr),
    .ex_syscall(ex_syscall), .ex_alu_op(ex_alu_op), .ex_use_rs(ex_use_rs), .ex_use_rt(ex_use_rt),
    .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_shamt(ex_shamt), .ex_dst(ex_dst),
    .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
  );

  typedef struct packed {
    logic          valid, beq, bne, mem_to_reg, mem_write, alu_src_b;
    logic          reg_write, reg_dst, jal, jmp, jr, syscall;
    logic [3:0]    alu_op;
    logic          use_rs, use_rt;
    logic [DW-1:0] pc, rs_data, rt_data, imm;
    logic [RW-1:0] rs, rt, rd, shamt;
  } instr_t;

  typedef struct packed {
    logic          valid, beq, bne, mem_to_reg, mem_write, alu_src_b;
    logic          reg_write, reg_dst, jal, jmp, jr, syscall;
    logic [3:0]    alu_op;
    logic          use_rs, use_rt;
    logic [DW-1:0] pc, rs_data, rt_data, imm;
    logic [RW-1:0] rs, rt, shamt, dst;
    logic [31:0]   cnt;
  } exv_t;

  exv_t dut_o;
  assign dut_o = {ex_valid, ex_beq, ex_bne, ex_mem_to_reg, ex_mem_write, ex_alu_src_b,
                  ex_reg_write, ex_reg_dst, ex_jal, ex_jmp, ex_jr, ex_syscall,
                  ex_alu_op, ex_use_rs, ex_use_rt, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
                  ex_rs, ex_rt, ex_shamt, ex_dst, bubble_cnt};

  exv_t        expq[$];
  exv_t        m_ex;
  logic [31:0] m_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference: what EX should hold after an instruction is accepted from ID.
  function automatic exv_t accept(instr_t i);
    exv_t e = '0;
    if (i.valid) begin
      e.valid = 1'b1;
      e.beq = i.beq; e.bne = i.bne; e.mem_to_reg = i.mem_to_reg; e.mem_write = i.mem_write;
      e.alu_src_b = i.alu_src_b; e.reg_write = i.reg_write; e.reg_dst = i.reg_dst;
      e.jal = i.jal; e.jmp = i.jmp; e.jr = i.jr; e.syscall = i.syscall;
      e.alu_op = i.alu_op; e.use_rs = i.use_rs; e.use_rt = i.use_rt;
      e.pc = i.pc; e.rs_data = i.rs_data; e.rt_data = i.rt_data; e.imm = i.imm;
      e.rs = i.rs; e.rt = i.rt; e.shamt = i.shamt;
      if (i.jal)          e.dst = 5'd31;
      else if (i.reg_dst) e.dst = i.rd;
      else                e.dst = i.rt;
    end
    return e;
  endfunction

  // ID needs a value that the load sitting in EX has not yet fetched.
  function automatic logic needs_loaded_value(instr_t i, exv_t ex, logic fl);
    logic reads;
    reads = (i.use_rs && i.rs == ex.dst) || (i.use_rt && i.rt == ex.dst);
    return i.valid && ex.valid && ex.mem_to_reg && ex.dst != 0 && reads && !fl;
  endfunction

  task automatic count_bubble();
`ifdef IDEX_BUBBLE_CNT_EN
    m_cnt = m_cnt + 32'd1;
`endif
  endtask

  task automatic push_expect();
    exv_t e = m_ex;
    e.cnt = m_cnt;
    expq.push_back(e);
  endtask

  task automatic apply(instr_t i, logic fl, logic hd);
    logic exp_stall;
    @(negedge clk);
    rst_n = 1'b1;
    id_valid = i.valid; id_beq = i.beq; id_bne = i.bne; id_mem_to_reg = i.mem_to_reg;
    id_mem_write = i.mem_write; id_alu_src_b = i.alu_src_b; id_reg_write = i.reg_write;
    id_reg_dst = i.reg_dst; id_jal = i.jal; id_jmp = i.jmp; id_jr = i.jr; id_syscall = i.syscall;
    id_alu_op = i.alu_op; id_use_rs = i.use_rs; id_use_rt = i.use_rt;
    id_pc = i.pc; id_rs_data = i.rs_data; id_rt_data = i.rt_data; id_imm = i.imm;
    id_rs = i.rs; id_rt = i.rt; id_rd = i.rd; id_shamt = i.shamt;
    flush = fl; hold = hd;
    #1;
    exp_stall = needs_loaded_value(i, m_ex, fl);
    n_tests++;
    if (load_use_stall !== exp_stall) begin
      n_fail++;
      $display("FAIL load_use_stall t=%0t got=%b exp=%b", $time, load_use_stall, exp_stall);
    end
    if (fl) begin
      m_ex = '0;
      count_bubble();
    end else if (hd) begin
      m_ex = m_ex;
    end else if (exp_stall) begin
      m_ex = '0;
      count_bubble();
    end else begin
      m_ex = accept(i);
    end
    push_expect();
  endtask

  task automatic async_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (dut_o !== '0) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=0", dut_o);
    end
    m_ex  = '0;
    m_cnt = '0;
    push_expect();
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    logic [RW-1:0] regs [4];
    regs[0] = 5'd0; regs[1] = 5'd8; regs[2] = 5'd9; regs[3] = 5'd10;
    i = '0;
    i.valid      = ($urandom_range(0, 9) != 0);
    i.beq        = 1'($urandom); i.bne = 1'($urandom);
    i.mem_to_reg = ($urandom_range(0, 9) < 4);
    i.mem_write  = 1'($urandom); i.alu_src_b = 1'($urandom); i.reg_write = 1'($urandom);
    i.reg_dst    = 1'($urandom); i.jal = ($urandom_range(0, 7) == 0);
    i.jmp        = 1'($urandom); i.jr = 1'($urandom); i.syscall = 1'($urandom);
    i.alu_op     = 4'($urandom);
    i.use_rs     = 1'($urandom); i.use_rt = 1'($urandom);
    i.pc = $urandom; i.rs_data = $urandom; i.rt_data = $urandom; i.imm = $urandom;
    i.rs = regs[$urandom_range(0, 3)]; i.rt = regs[$urandom_range(0, 3)];
    i.rd = regs[$urandom_range(0, 3)]; i.shamt = 5'($urandom);
    return i;
  endfunction

  // Monitor: one registered result per clock edge once the scoreboard has entries.
  initial begin
    exv_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        n_tests++;
        if (dut_o !== e) begin
          n_fail++;
          $display("FAIL ex_bundle t=%0t got=%h exp=%h", $time, dut_o, e);
        end
      end
    end
  end

  initial begin
    instr_t lw8, add9, lw0, rd0, sw9, ori, jal_i, add5, addi7, nop;
    rst_n = 1'b0;
    {id_valid, id_beq, id_bne, id_mem_to_reg, id_mem_write, id_alu_src_b, id_reg_write,
     id_reg_dst, id_jal, id_jmp, id_jr, id_syscall, id_use_rs, id_use_rt} = '0;
    id_alu_op = '0; id_pc = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_shamt = '0;
    flush = 1'b0; hold = 1'b0;
    m_ex = '0; m_cnt = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (dut_o !== '0) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=0", dut_o);
    end

    nop = '0;
    lw8 = '0;  lw8.valid = 1; lw8.mem_to_reg = 1; lw8.reg_write = 1; lw8.alu_src_b = 1;
    lw8.rs = 5'd29; lw8.rt = 5'd8; lw8.use_rs = 1; lw8.imm = 32'h10; lw8.pc = 32'h0040_0000;
    add9 = '0; add9.valid = 1; add9.reg_write = 1; add9.reg_dst = 1; add9.use_rs = 1;
    add9.use_rt = 1; add9.rs = 5'd8; add9.rt = 5'd10; add9.rd = 5'd9; add9.alu_op = 4'd2;
    add9.pc = 32'h0040_0004; add9.rs_data = 32'h1234; add9.rt_data = 32'h5678;
    lw0 = lw8; lw0.rt = 5'd0;
    rd0 = add9; rd0.rs = 5'd0; rd0.rt = 5'd0;
    sw9 = '0; sw9.valid = 1; sw9.mem_write = 1; sw9.alu_src_b = 1; sw9.use_rs = 1;
    sw9.use_rt = 0; sw9.rs = 5'd9; sw9.rt = 5'd8; sw9.imm = 32'h4;
    ori = '0; ori.valid = 1; ori.reg_write = 1; ori.alu_src_b = 1; ori.use_rs = 1;
    ori.rs = 5'd3; ori.rt = 5'd4; ori.imm = 32'h00FF; ori.alu_op = 4'd5; ori.pc = 32'h0040_0020;
    jal_i = '0; jal_i.valid = 1; jal_i.jal = 1; jal_i.reg_write = 1; jal_i.pc = 32'h0040_0010;
    jal_i.rt = 5'd3; jal_i.rd = 5'd6;
    add5 = add9; add5.rd = 5'd5; add5.rs = 5'd1; add5.rt = 5'd2;
    addi7 = ori; addi7.rt = 5'd7; addi7.rd = 5'd12; addi7.reg_dst = 0;

    // lw then dependent add: one bubble, add re-presented and captured.
    apply(lw8, 0, 0); apply(add9, 0, 0); apply(add9, 0, 0); apply(nop, 0, 0);
    // loads into $0 and non-reading stores do not stall.
    apply(lw0, 0, 0); apply(rd0, 0, 0);
    apply(lw8, 0, 0); apply(sw9, 0, 0);
    // flush overrides load-use, and flush wins over hold.
    apply(lw8, 0, 0); apply(add9, 1, 0);
    apply(ori, 0, 0); apply(add9, 1, 1);
    // three held edges, then capture on release.
    apply(ori, 0, 0); apply(add9, 0, 1); apply(add9, 0, 1); apply(add9, 0, 1); apply(add9, 0, 0);
    // load-use while held: stall visible, registers frozen.
    apply(lw8, 0, 0); apply(add9, 0, 1); apply(add9, 0, 0); apply(add9, 0, 0);
    // destination selection.
    apply(jal_i, 0, 0); apply(add5, 0, 0); apply(addi7, 0, 0);
    // asynchronous reset with a valid instruction in EX, then capture on release.
    apply(ori, 0, 0); async_reset(); apply(add5, 0, 0);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      else apply(rand_instr(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
    end

    repeat (2) @(negedge clk);
    n_tests++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
